// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    // Requester side: issues operations, observes results.
    modport master (
        output start, sub, A, B, Cin,
        input  busy, done, Sum, Cout, Ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  start, sub, A, B, Cin,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT chained full-adder slices per clock,
// carry registered between cycles, results published only on completion.
module serial_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int unsigned NumDigits = WIDTH / DIGIT;
    localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("serial_addsub: DIGIT must divide WIDTH exactly and WIDTH must be >= 2");
    end

    typedef enum logic {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;         // holds ~B when subtracting
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [DIGIT:0]       c;
    logic [DIGIT-1:0]     s;
    logic [WIDTH+DIGIT:0] sum_cat;
    logic [WIDTH-1:0]     sum_shift;
    logic                 last_digit;

    // Ripple the registered carry through DIGIT full-adder slices.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]   = a_q[i] ^ b_q[i] ^ c[i];
            c[i+1] = (a_q[i] & b_q[i]) | (a_q[i] & c[i]) | (b_q[i] & c[i]);
        end
    end

    // New digit enters at the MSB end; after N digits the register holds the full result.
    assign sum_cat    = {1'b0, s, sum_shift_src()};
    assign sum_shift  = WIDTH'(sum_cat >> DIGIT);
    assign last_digit = (cnt_q == CntW'(NumDigits - 1));

    function automatic logic [WIDTH-1:0] sum_shift_src();
        return sum_sh_q;
    endfunction

    // Next-state and datapath updates for the IDLE/RUN controller.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    a_d     = bus.A;
                    b_d     = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub ^ bus.Cin;  // borrow-in becomes inverted carry-in
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                sum_sh_d = sum_shift;
                carry_d  = c[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    sum_d   = sum_shift;
                    cout_d  = c[DIGIT];
                    ovf_d   = c[DIGIT] ^ c[DIGIT-1];  // carry into MSB vs out of MSB
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and published-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = done_q;
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: 8-bit digit-1 and digit-4 units driven in
// lockstep, plus an exhaustive sweep of a 4-bit unit against a reference model.
module tb_serial_addsub;
    logic clk;
    logic rst_n;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_addsub_if #(.WIDTH(8)) b8 ();
    serial_addsub_if #(.WIDTH(8)) b84 ();
    serial_addsub_if #(.WIDTH(4)) b4 ();

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d84 (.clk(clk), .rst_n(rst_n), .bus(b84));
    serial_addsub #(.WIDTH(4), .DIGIT(1)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow from operand/result signs.
    function automatic logic [9:0] model(input int w, input logic sb, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
        logic [8:0] m;
        logic [8:0] bb;
        logic [8:0] full;
        logic       cc;
        logic [9:0] r;
        m      = 9'((1 << w) - 1);
        bb     = {1'b0, (sb ? ~b : b)} & m;
        cc     = sb ? ~ci : ci;
        full   = {1'b0, a} + bb + {8'b0, cc};
        r      = '0;
        r[7:0] = full[7:0] & m[7:0];
        r[8]   = full[w];
        r[9]   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
        return r;
    endfunction

    task automatic drive8(input logic st, input logic sb, input logic [7:0] a,
                          input logic [7:0] b, input logic ci);
        b8.start  = st;  b8.sub  = sb;  b8.A  = a;  b8.B  = b;  b8.Cin  = ci;
        b84.start = st;  b84.sub = sb;  b84.A = a;  b84.B = b;  b84.Cin = ci;
    endtask

    task automatic drive4(input logic st, input logic sb, input logic [3:0] a,
                          input logic [3:0] b, input logic ci);
        b4.start = st;  b4.sub = sb;  b4.A = a;  b4.B = b;  b4.Cin = ci;
    endtask

    // Start one op on both 8-bit units; latency counted in edges after acceptance.
    task automatic run8(input logic sb, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, output int lat, output int lat4, output int busy_lo);
        @(negedge clk);
        drive8(1'b1, sb, a, b, ci);
        @(posedge clk);
        #1;
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        lat     = -1;
        lat4    = -1;
        busy_lo = (b8.busy) ? 0 : 1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b84.done && lat4 < 0) lat4 = i;
            if (b8.done) begin
                lat = i;
                break;
            end
            if (!b8.busy) busy_lo++;
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] s, input logic co, input logic ov,
                          input int lat, input int lat4, input int busy_lo);
        chk({tag, "_sum"}, 32'(b8.Sum), 32'(s));
        chk({tag, "_cout"}, 32'(b8.Cout), 32'(co));
        chk({tag, "_ovf"}, 32'(b8.Ovf), 32'(ov));
        chk({tag, "_lat"}, 32'(lat), 32'd8);
        chk({tag, "_busy"}, 32'(busy_lo), 32'd0);
        chk({tag, "_busydone"}, 32'(b8.busy), 32'd0);
        chk({tag, "_d4res"}, 32'({b84.Ovf, b84.Cout, b84.Sum}), 32'({ov, co, s}));
        chk({tag, "_d4lat"}, 32'(lat4), 32'd2);
        @(posedge clk);
        #1;
        chk({tag, "_single"}, 32'(b8.done), 32'd0);
    endtask

    task automatic run4(input logic sb, input logic [3:0] a, input logic [3:0] b,
                        input logic ci, output int lat);
        @(negedge clk);
        drive4(1'b1, sb, a, b, ci);
        @(posedge clk);
        #1;
        drive4(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (b4.done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          lat4;
        int          busy_lo;
        int          holds;
        int          seen;
        logic [9:0]  m;
        logic [31:0] obs;
        logic [31:0] exp;

        rst_n = 1'b0;
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive4(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'({b8.busy, b8.done, b8.Cout, b8.Ovf, b8.Sum}), 32'd0);
        chk("rst_outs4", 32'({b4.busy, b4.done, b4.Cout, b4.Ovf, b4.Sum}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow on add.
        run8(1'b0, 8'h7F, 8'h01, 1'b0, lat, lat4, busy_lo);
        check8("add7f01", 8'h80, 1'b0, 1'b1, lat, lat4, busy_lo);
        // Wrap-around with carry out.
        run8(1'b0, 8'hFF, 8'h01, 1'b0, lat, lat4, busy_lo);
        check8("addff01", 8'h00, 1'b1, 1'b0, lat, lat4, busy_lo);
        run8(1'b0, 8'hFF, 8'h00, 1'b1, lat, lat4, busy_lo);
        check8("addff00c", 8'h00, 1'b1, 1'b0, lat, lat4, busy_lo);
        // Subtract: borrow, signed overflow, borrow-in.
        run8(1'b1, 8'h05, 8'h07, 1'b0, lat, lat4, busy_lo);
        check8("sub0507", 8'hFE, 1'b0, 1'b0, lat, lat4, busy_lo);
        run8(1'b1, 8'h80, 8'h01, 1'b0, lat, lat4, busy_lo);
        check8("sub8001", 8'h7F, 1'b1, 1'b1, lat, lat4, busy_lo);
        run8(1'b1, 8'h10, 8'h01, 1'b1, lat, lat4, busy_lo);
        check8("sub1001b", 8'h0E, 1'b1, 1'b0, lat, lat4, busy_lo);

        // Start while busy is ignored; result held until completion.
        @(negedge clk);
        drive8(1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
        @(posedge clk);
        #1;
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive8(1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);
        @(posedge clk);
        #1;
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("ign_busy", 32'(b8.busy), 32'd1);
        chk("ign_hold", 32'(b8.Sum), 32'h0E);
        lat   = -1;
        holds = 0;
        for (int i = 4; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b8.done) begin
                lat = i;
                break;
            end
            if (b8.Sum !== 8'h0E || b8.Cout !== 1'b1) holds++;
        end
        chk("ign_lat", 32'(lat), 32'd8);
        chk("ign_midrun", 32'(holds), 32'd0);
        chk("ign_res", 32'({b8.Ovf, b8.Cout, b8.Sum}), 32'({1'b0, 1'b0, 8'h46}));

        // Back-to-back: start in the done cycle.
        drive8(1'b1, 1'b1, 8'h20, 8'h03, 1'b0);
        @(posedge clk);
        #1;
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("b2b_accept", 32'({b8.busy, b8.done}), 32'b10);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b8.done) begin
                lat = i;
                break;
            end
        end
        chk("b2b_lat", 32'(lat), 32'd8);
        chk("b2b_res", 32'({b8.Ovf, b8.Cout, b8.Sum}), 32'({1'b0, 1'b1, 8'h1D}));

        // Asynchronous reset mid-run.
        @(negedge clk);
        drive8(1'b1, 1'b0, 8'h33, 8'h11, 1'b0);
        @(posedge clk);
        #1;
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outs", 32'({b8.busy, b8.done, b8.Cout, b8.Ovf, b8.Sum}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (b8.done || b8.busy) seen++;
        end
        chk("arst_nodone", 32'(seen), 32'd0);
        run8(1'b0, 8'h33, 8'h11, 1'b0, lat, lat4, busy_lo);
        check8("arst_fresh", 8'h44, 1'b0, 1'b0, lat, lat4, busy_lo);

        // Exhaustive 4-bit sweep.
        for (int sb = 0; sb < 2; sb++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    for (int ci = 0; ci < 2; ci++) begin
                        run4(1'(sb), 4'(a), 4'(b), 1'(ci), lat);
                        m   = model(4, 1'(sb), 8'(a), 8'(b), 1'(ci));
                        obs = {16'(lat), 6'b0, b4.Ovf, b4.Cout, 4'b0, b4.Sum};
                        exp = {16'd4, 6'b0, m[9], m[8], 4'b0, m[3:0]};
                        chk($sformatf("w4_s%0d_a%0h_b%0h_c%0d", sb, a, b, ci), obs, exp);
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
